// File: rtl/alu_unit.sv
// ----------------------------------------------------------------------------
// alu_unit
// RV32I execute-stage block: decodes opcode/funct3/bit30 into a 4-bit ALU
// operation, evaluates a 32-bit combinational ALU on operands A and B, and
// keeps a registered copy of the result for the EX/MEM boundary.
//
// Out and ALUop are purely combinational so same-cycle consumers
// (forwarding, branch-target logic) see them with zero latency. OutReg is
// the only state element in the block.
// ----------------------------------------------------------------------------
module alu_unit (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct,
    input  logic        add_rshift_type,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [3:0]  ALUop,
    output logic [31:0] Out,
    output logic [31:0] OutReg
);

    // ------------------------------------------------------------------
    // ALU operation encoding
    // ------------------------------------------------------------------
    localparam logic [3:0] ALU_ADD     = 4'd0;
    localparam logic [3:0] ALU_SUB     = 4'd1;
    localparam logic [3:0] ALU_SLL     = 4'd2;
    localparam logic [3:0] ALU_SLT     = 4'd3;
    localparam logic [3:0] ALU_SLTU    = 4'd4;
    localparam logic [3:0] ALU_XOR     = 4'd5;
    localparam logic [3:0] ALU_SRL     = 4'd6;
    localparam logic [3:0] ALU_SRA     = 4'd7;
    localparam logic [3:0] ALU_OR      = 4'd8;
    localparam logic [3:0] ALU_AND     = 4'd9;
    localparam logic [3:0] ALU_COPY_B  = 4'd10;
    localparam logic [3:0] ALU_ILLEGAL = 4'd15;

    // ------------------------------------------------------------------
    // RV32I major opcodes handled by the decoder
    // ------------------------------------------------------------------
    localparam logic [6:0] OPC_OP     = 7'b0110011;  // R-type arithmetic
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;  // I-type arithmetic
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    // ------------------------------------------------------------------
    // funct3 values of the arithmetic group
    // ------------------------------------------------------------------
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SR      = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    // ------------------------------------------------------------------
    // Map funct3 (+ bit 30) of the arithmetic group to an ALU operation.
    // The immediate form has no SUBI: bit 30 belongs to the immediate
    // there, so only the shift-right selection honours it.
    // ------------------------------------------------------------------
    function automatic logic [3:0] arith_op(input logic [2:0] f3,
                                            input logic       bit30,
                                            input logic       is_imm);
        logic [3:0] op;
        op = ALU_ILLEGAL;
        case (f3)
            F3_ADD_SUB: op = (bit30 && !is_imm) ? ALU_SUB : ALU_ADD;
            F3_SLL:     op = ALU_SLL;
            F3_SLT:     op = ALU_SLT;
            F3_SLTU:    op = ALU_SLTU;
            F3_XOR:     op = ALU_XOR;
            F3_SR:      op = bit30 ? ALU_SRA : ALU_SRL;
            F3_OR:      op = ALU_OR;
            F3_AND:     op = ALU_AND;
            default:    op = ALU_ILLEGAL;
        endcase
        return op;
    endfunction

    // ------------------------------------------------------------------
    // Logical / arithmetic right shift with a selectable fill bit.
    // Only the low five bits of the shift amount are meaningful.
    // ------------------------------------------------------------------
    function automatic logic [31:0] shift_right(input logic [31:0] value,
                                                input logic [4:0]  shamt,
                                                input logic        fill);
        logic [63:0] ext;
        ext = {{32{fill}}, value} >> shamt;
        return ext[31:0];
    endfunction

    // ------------------------------------------------------------------
    // Internal signals
    // ------------------------------------------------------------------
    logic [3:0]  aluop_s;
    logic [31:0] sum_s;       // A + B (mod 2^32)
    logic [32:0] diff_s;      // A - B with borrow-out in bit 32
    logic        ltu_s;       // unsigned A < B
    logic        lt_s;        // signed A < B
    logic [4:0]  shamt_s;
    logic [31:0] sll_s;
    logic [31:0] srl_s;
    logic [31:0] sra_s;
    logic [31:0] result_s;
    logic [31:0] out_r;

    // Decode opcode/funct3/bit30 into the ALU operation.
    always_comb begin
        aluop_s = ALU_ILLEGAL;
        case (opcode)
            OPC_OP:     aluop_s = arith_op(funct, add_rshift_type, 1'b0);
            OPC_OP_IMM: aluop_s = arith_op(funct, add_rshift_type, 1'b1);
            OPC_LUI:    aluop_s = ALU_COPY_B;
            // Address / link computations all reduce to an addition.
            OPC_AUIPC,
            OPC_JAL,
            OPC_JALR,
            OPC_BRANCH,
            OPC_LOAD,
            OPC_STORE:  aluop_s = ALU_ADD;
            default:    aluop_s = ALU_ILLEGAL;
        endcase
    end

    // Shared arithmetic: a single subtractor provides both SUB and the
    // compare results. Bit 32 of A + ~B + 1 is set exactly when A >= B
    // unsigned; for the signed compare, differing signs decide directly,
    // otherwise the difference cannot overflow and its sign is the answer.
    always_comb begin
        sum_s   = A + B;
        diff_s  = {1'b0, A} + {1'b0, ~B} + 33'd1;
        ltu_s   = ~diff_s[32];
        if (A[31] != B[31]) begin
            lt_s = A[31];
        end else begin
            lt_s = diff_s[31];
        end
        shamt_s = B[4:0];
        sll_s   = A << shamt_s;
        srl_s   = shift_right(A, shamt_s, 1'b0);
        sra_s   = shift_right(A, shamt_s, A[31]);
    end

    // Select the ALU result for the decoded operation; undefined
    // operations produce zero.
    always_comb begin
        result_s = 32'h0000_0000;
        case (aluop_s)
            ALU_ADD:    result_s = sum_s;
            ALU_SUB:    result_s = diff_s[31:0];
            ALU_SLL:    result_s = sll_s;
            ALU_SLT:    result_s = {31'd0, lt_s};
            ALU_SLTU:   result_s = {31'd0, ltu_s};
            ALU_XOR:    result_s = A ^ B;
            ALU_SRL:    result_s = srl_s;
            ALU_SRA:    result_s = sra_s;
            ALU_OR:     result_s = A | B;
            ALU_AND:    result_s = A & B;
            ALU_COPY_B: result_s = B;
            default:    result_s = 32'h0000_0000;
        endcase
    end

    // Result register toward the next pipeline stage; cleared
    // asynchronously and loaded on every edge otherwise.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            out_r <= 32'h0000_0000;
        end else begin
            out_r <= result_s;
        end
    end

    assign ALUop  = aluop_s;
    assign Out    = result_s;
    assign OutReg = out_r;

endmodule

// File: tb/tb_alu_unit.sv
// ----------------------------------------------------------------------------
// tb_alu_unit
// Directed vectors for alu_unit. The stimulus process drives one vector per
// clock cycle (shortly after the rising edge) and pushes the hand-computed
// expectation into a scoreboard queue; the monitor process pops one entry
// on every falling edge and compares it against the DUT outputs.
// ----------------------------------------------------------------------------
module tb_alu_unit;

    logic        Clock;
    logic        Reset_n;
    logic [6:0]  opcode;
    logic [2:0]  funct;
    logic        add_rshift_type;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  ALUop;
    logic [31:0] Out;
    logic [31:0] OutReg;

    alu_unit dut (
        .Clock           (Clock),
        .Reset_n         (Reset_n),
        .opcode          (opcode),
        .funct           (funct),
        .add_rshift_type (add_rshift_type),
        .A               (A),
        .B               (B),
        .ALUop           (ALUop),
        .Out             (Out),
        .OutReg          (OutReg)
    );

    typedef struct packed {
        logic [3:0]  aluop;
        logic [31:0] out;
        logic [31:0] outreg;
        logic        chk_aluop;
        logic        chk_out;
        logic        chk_outreg;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];

    int n_vectors;
    int n_miscompares;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    // Free-running clock, 10 time units per period.
    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Push one expectation entry together with its name.
    task automatic push_exp(input string nm, input logic [3:0] ea,
                            input logic [31:0] eo, input logic [31:0] er,
                            input logic ca, input logic co, input logic cr);
        exp_t e;
        e.aluop      = ea;
        e.out        = eo;
        e.outreg     = er;
        e.chk_aluop  = ca;
        e.chk_out    = co;
        e.chk_outreg = cr;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Drive a combinational vector after the next rising edge and queue its
    // expected ALUop and Out.
    task automatic apply(input string nm, input logic [6:0] op,
                         input logic [2:0] f3, input logic b30,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] ea, input logic [31:0] eo);
        @(posedge Clock);
        #1;
        opcode          = op;
        funct           = f3;
        add_rshift_type = b30;
        A               = a;
        B               = b;
        push_exp(nm, ea, eo, 32'h0, 1'b1, 1'b1, 1'b0);
    endtask

    // Monitor: one scoreboard entry per falling edge.
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(negedge Clock);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (e.chk_aluop) begin
                    n_vectors++;
                    if (ALUop !== e.aluop) begin
                        n_miscompares++;
                        $display("FAIL %s ALUop: got %0d expected %0d", nm, ALUop, e.aluop);
                    end
                end
                if (e.chk_out) begin
                    n_vectors++;
                    if (Out !== e.out) begin
                        n_miscompares++;
                        $display("FAIL %s Out: got 0x%08h expected 0x%08h", nm, Out, e.out);
                    end
                end
                if (e.chk_outreg) begin
                    n_vectors++;
                    if (OutReg !== e.outreg) begin
                        n_miscompares++;
                        $display("FAIL %s OutReg: got 0x%08h expected 0x%08h", nm, OutReg, e.outreg);
                    end
                end
            end
        end
    end

    // Stimulus.
    initial begin
        n_vectors       = 0;
        n_miscompares   = 0;
        Reset_n         = 1'b0;
        opcode          = 7'b0000000;
        funct           = 3'b000;
        add_rshift_type = 1'b0;
        A               = 32'h0;
        B               = 32'h0;

        // Reset state of the result register.
        @(posedge Clock);
        #1;
        push_exp("reset_outreg", 4'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        @(posedge Clock);
        #1;
        Reset_n = 1'b1;

        // R-type add/sub with signed-overflow operands (mod 2^32).
        apply("r_add",  OP_R, 3'b000, 1'b0, 32'h7FFF_FFFF, 32'h1, 4'd0, 32'h8000_0000);
        apply("r_sub",  OP_R, 3'b000, 1'b1, 32'h7FFF_FFFF, 32'h1, 4'd1, 32'h7FFF_FFFE);
        apply("r_sub_wrap", OP_R, 3'b000, 1'b1, 32'h0, 32'h1, 4'd1, 32'hFFFF_FFFF);

        // Shifts: only B[4:0] = 4 used.
        apply("srai",   OP_I, 3'b101, 1'b1, 32'h8000_0000, 32'h24, 4'd7, 32'hF800_0000);
        apply("srli",   OP_I, 3'b101, 1'b0, 32'h8000_0000, 32'h24, 4'd6, 32'h0800_0000);
        apply("slli",   OP_I, 3'b001, 1'b0, 32'h8000_0000, 32'h24, 4'd2, 32'h0000_0000);
        apply("r_sra31", OP_R, 3'b101, 1'b1, 32'h8000_0001, 32'h1F, 4'd7, 32'hFFFF_FFFF);
        apply("r_sll1",  OP_R, 3'b001, 1'b0, 32'h0000_0003, 32'h21, 4'd2, 32'h0000_0006);

        // Compares.
        apply("slt_neg",  OP_R, 3'b010, 1'b0, 32'hFFFF_FFFF, 32'h1, 4'd3, 32'h1);
        apply("sltu_big", OP_R, 3'b011, 1'b0, 32'hFFFF_FFFF, 32'h1, 4'd4, 32'h0);
        apply("slt_pos",  OP_R, 3'b010, 1'b0, 32'h1, 32'hFFFF_FFFF, 4'd3, 32'h0);
        apply("sltu_sml", OP_R, 3'b011, 1'b0, 32'h1, 32'hFFFF_FFFF, 4'd4, 32'h1);
        apply("slt_eq",   OP_R, 3'b010, 1'b0, 32'h8000_0000, 32'h8000_0000, 4'd3, 32'h0);
        apply("slti_ovf", OP_I, 3'b010, 1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 4'd3, 32'h1);

        // Logic ops.
        apply("r_or",   OP_R, 3'b110, 1'b0, 32'hF0F0_0000, 32'h0F0F_00FF, 4'd8, 32'hFFFF_00FF);
        apply("r_and",  OP_R, 3'b111, 1'b0, 32'hF0F0_FFFF, 32'h0FF0_00FF, 4'd9, 32'h00F0_00FF);

        // Non-arithmetic opcodes.
        apply("lui",    OP_LUI,     3'b000, 1'b0, 32'h1000, 32'h20, 4'd10, 32'h20);
        apply("load",   7'b0000011, 3'b010, 1'b0, 32'h1000, 32'h20, 4'd0,  32'h1020);
        apply("store",  7'b0100011, 3'b010, 1'b0, 32'h1000, 32'h20, 4'd0,  32'h1020);
        apply("branch", 7'b1100011, 3'b001, 1'b1, 32'h1000, 32'h20, 4'd0,  32'h1020);
        apply("jal",    7'b1101111, 3'b000, 1'b0, 32'h1000, 32'h20, 4'd0,  32'h1020);
        apply("jalr",   7'b1100111, 3'b000, 1'b0, 32'h1000, 32'h20, 4'd0,  32'h1020);
        apply("auipc",  7'b0010111, 3'b111, 1'b1, 32'h1000, 32'h20, 4'd0,  32'h1020);
        apply("illegal", 7'b1111111, 3'b000, 1'b0, 32'h1000, 32'h20, 4'd15, 32'h0);

        // I-type funct 000 ignores bit 30.
        apply("addi_b30", OP_I, 3'b000, 1'b1, 32'h5, 32'h3, 4'd0, 32'h8);

        // Result register and asynchronous reset.
        apply("xor", OP_R, 3'b100, 1'b0, 32'hF0F0_F0F0, 32'hFFFF_0000, 4'd5, 32'h0F0F_F0F0);
        @(posedge Clock);
        #1;
        push_exp("outreg_load", 4'd5, 32'h0F0F_F0F0, 32'h0F0F_F0F0, 1'b1, 1'b1, 1'b1);
        @(posedge Clock);
        #1;
        Reset_n = 1'b0;
        push_exp("outreg_async_rst", 4'd5, 32'h0F0F_F0F0, 32'h0, 1'b1, 1'b1, 1'b1);
        @(posedge Clock);
        #1;
        Reset_n = 1'b1;
        push_exp("outreg_held_rst", 4'd5, 32'h0F0F_F0F0, 32'h0, 1'b1, 1'b1, 1'b1);
        @(posedge Clock);
        #1;
        push_exp("outreg_reload", 4'd5, 32'h0F0F_F0F0, 32'h0F0F_F0F0, 1'b1, 1'b1, 1'b1);

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge Clock);
        end
        @(posedge Clock);
        if (exp_q.size() != 0) begin
            n_miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

// File: doc/alu_unit.md
# alu_unit

RV32I integer execute block: an opcode/funct decoder (ALU-op generation) feeding a 32-bit combinational ALU, with a registered copy of the result. It sits in the execute stage between operand muxing (A/B selection, not part of this block) and the EX/MEM boundary. The combinational result serves same-cycle consumers such as forwarding and branch-target logic. The registered result feeds the next pipeline stage.

## Interface
- No parameters; datapath width fixed at 32.
- Clock  input  1  rising-edge clock; clocks the result register only.
- Reset_n  input  1  asynchronous, active-low reset.
- opcode  input  7  instruction bits [6:0].
- funct  input  3  instruction funct3, bits [14:12].
- add_rshift_type  input  1  instruction bit 30; selects SUB vs ADD and SRA vs SRL.
- A  input  32  operand A (rs1 or PC).
- B  input  32  operand B (rs2 or immediate).
- ALUop  output  4  decoded operation; purely combinational.
- Out  output  32  combinational result of A, B, ALUop.
- OutReg  output  32  Out registered on the rising edge of Clock.

## Operation

**ALUop encoding**
- 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 COPY_B.
- 11–15 are illegal/undefined; ALUdec emits 15 for them.

**Decode**
- R-type 0110011: funct 000 gives SUB if add_rshift_type=1, otherwise ADD.
- R-type funct map: 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND.
- R-type funct 101 gives SRA if add_rshift_type=1, otherwise SRL.
- I-type arithmetic 0010011: same map as R-type, except funct 000 is always ADD (add_rshift_type ignored).
- I-type arithmetic, funct 101: add_rshift_type selects SRAI vs SRLI.
- LUI 0110111 → COPY_B.
- ADD for all of: AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011.
- Any other opcode → 15.

**ALU arithmetic and width rules**
- ADD/SUB are modulo 2^32; no carry or overflow output.
- Shifts use B[4:0] only; B[31:5] is ignored.
- SRA replicates A[31] into the vacated bits; SRL zero-fills.
- SLT compares as two's-complement; SLTU compares unsigned. Result is 32'h1 if A<B, else 32'h0.
- COPY_B: Out = B.
- Any undefined ALUop: Out = 32'h0.

**Result register**
- OutReg loads Out on every rising Clock edge while Reset_n=1.
- There is no enable; OutReg holds the latest value until the next edge.

## Timing
- ALUop and Out are combinational with zero cycle latency.
- ALUop and Out settle within one cycle of any change to opcode, funct, add_rshift_type, A or B.
- Out is independent of Clock and Reset_n.
- OutReg has one-cycle latency: the value of Out just before edge N appears on OutReg after edge N.
- Reset_n low: OutReg goes to 32'h0 immediately (asynchronously) and holds 0 while Reset_n is low.
- Reset_n deasserting coincident with a clock edge: OutReg stays 0 for that edge and loads normally from the following edge.
- Reset mid-stream does not disturb ALUop or Out.
- No state other than OutReg; no handshakes.

## Test plan
- **R-type ADD/SUB:** opcode 0110011, funct 000, A=0x7FFFFFFF, B=1.
  - add_rshift_type=0 → ALUop 0, Out=0x80000000.
  - add_rshift_type=1 → ALUop 1, Out=0x7FFFFFFE.
- **Shifts:** opcode 0010011, funct 101, A=0x80000000, B=0x00000024.
  - add_rshift_type=1 → Out=0xF8000000 (shift amount 4; B[31:5] ignored).
  - add_rshift_type=0 → Out=0x08000000.
  - funct 001, same A/B → Out=0x00000000.
- **Compares:** opcode 0110011, A=0xFFFFFFFF, B=0x00000001.
  - funct 010 (SLT) → Out=1.
  - funct 011 (SLTU) → Out=0.
- **Non-arithmetic opcodes:** A=0x1000, B=0x20.
  - LUI → ALUop 10, Out=0x20.
  - LOAD, STORE, BRANCH, JAL, JALR, AUIPC → ALUop 0, Out=0x1020.
  - opcode 1111111 → ALUop 15, Out=0.
- **I-type funct 000 with bit 30 set:** opcode 0010011, funct 000, add_rshift_type=1, A=5, B=3 → ADD, Out=8.
- **Register and reset:** drive XOR with A=0xF0F0F0F0, B=0xFFFF0000, giving Out=0x0F0FF0F0.
  - OutReg=0x0F0FF0F0 after one rising edge.
  - Pull Reset_n low between edges → OutReg=0 immediately.
  - Release Reset_n → OutReg reloads 0x0F0FF0F0 on the next edge.
